// File: rtl/lstm_mem_pkg.sv
// lstm_mem_pkg
//   Types and defaults shared by the LSTM weight memory blocks.
//   - load_state_e : weight loader FSM encoding
//   - DEF_RAM_*    : default geometry of the weight RAM instances
package lstm_mem_pkg;

  localparam int DEF_RAM_WIDTH = 16;
  localparam int DEF_RAM_DEPTH = 400;
  localparam int DEF_RAM_ADDR  = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } load_state_e;

endpackage

// File: rtl/weight_stream_loader.sv
// weight_stream_loader
//   Converts a valid/ready stream of weight words into sequential write
//   strobes for a single-port weight RAM (addresses 0..RAM_DEPTH-1). Once the
//   last word is written, ce0 is held high for SCAN_LEN cycles so the RAM's
//   free-running scan refreshes every slot of its flat output bus, then
//   weights_ready is raised until the next start.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           1-cycle pulse, starts a load from IDLE or DONE
//   s_valid/s_ready stream handshake; s_data word, s_last end-of-load marker
//   ce1/we1/addr1/win  RAM write port (registered, 1-cycle strobe per word)
//   ce0             RAM scan/read enable
//   busy            loading or scanning
//   weights_ready   level, RAM contents complete and refreshed
//   err             sticky s_last position error, cleared by start
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start (after reset or an aborted load)
// ST_LOAD | accepting words, one write strobe per transfer
// ST_SCAN | ce0 held high while the RAM scan sweeps all entries
// ST_DONE | weights_ready high, waiting for start
module weight_stream_loader
  import lstm_mem_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int RAM_ADDR  = DEF_RAM_ADDR,
  parameter int SCAN_LEN  = RAM_DEPTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [RAM_WIDTH-1:0] s_data,
  input  logic                 s_last,
  output logic                 ce1,
  output logic                 we1,
  output logic [RAM_ADDR-1:0]  addr1,
  output logic [RAM_WIDTH-1:0] win,
  output logic                 ce0,
  output logic                 busy,
  output logic                 weights_ready,
  output logic                 err
);

  localparam int SW = $clog2(SCAN_LEN + 1);
  localparam logic [RAM_ADDR-1:0] LAST_ADDR = RAM_ADDR'(RAM_DEPTH - 1);

  load_state_e         state;
  logic [RAM_ADDR-1:0] wcnt;
  logic [SW-1:0]       scnt;
  logic                xfer;

  assign xfer = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wcnt          <= '0;
      scnt          <= '0;
      s_ready       <= 1'b0;
      ce1           <= 1'b0;
      we1           <= 1'b0;
      addr1         <= '0;
      win           <= '0;
      ce0           <= 1'b0;
      busy          <= 1'b0;
      weights_ready <= 1'b0;
      err           <= 1'b0;
    end else begin
      ce1 <= 1'b0;
      we1 <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_LOAD;
            s_ready       <= 1'b1;
            busy          <= 1'b1;
            weights_ready <= 1'b0;
            err           <= 1'b0;
            wcnt          <= '0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            // Every accepted word is written, including one that aborts the load.
            ce1   <= 1'b1;
            we1   <= 1'b1;
            addr1 <= wcnt;
            win   <= s_data;
            if (wcnt == LAST_ADDR) begin
              // wcnt stays at the last address; it is cleared by the next start.
              state   <= ST_SCAN;
              s_ready <= 1'b0;
              ce0     <= 1'b1;
              scnt    <= SW'(SCAN_LEN);
              if (!s_last) err <= 1'b1;
            end else if (s_last) begin
              state   <= ST_IDLE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              err     <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ST_SCAN: begin
          // Down-counter loaded with SCAN_LEN; terminal count 1 ends the scan
          // so ce0 covers exactly SCAN_LEN cycles.
          if (scnt == SW'(1)) begin
            state         <= ST_DONE;
            ce0           <= 1'b0;
            busy          <= 1'b0;
            weights_ready <= 1'b1;
            scnt          <= '0;
          end else begin
            scnt <= scnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
